// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// ALU operation codes and datapath select codes.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_IMM_EXEC  = 4'd10,
      S_IMM_WB    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [2:0] ALU_OP_ADD   = 3'b000;
   localparam logic [2:0] ALU_OP_SUB   = 3'b001;
   localparam logic [2:0] ALU_OP_FUNCT = 3'b010;
   localparam logic [2:0] ALU_OP_AND   = 3'b011;
   localparam logic [2:0] ALU_OP_OR    = 3'b100;
   localparam logic [2:0] ALU_OP_SLT   = 3'b101;

   localparam logic [1:0] ALU_B_REG     = 2'b00;
   localparam logic [1:0] ALU_B_FOUR    = 2'b01;
   localparam logic [1:0] ALU_B_IMM     = 2'b10;
   localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   function automatic logic is_imm_op(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
   endfunction

   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      case (op)
         OP_SLTI: return ALU_OP_SLT;
         OP_ANDI: return ALU_OP_AND;
         OP_ORI:  return ALU_OP_OR;
         default: return ALU_OP_ADD;
      endcase
   endfunction

   // Logical immediates are zero-extended; everything else sign-extends.
   function automatic logic imm_ext_op(input logic [5:0] op);
      return !((op == OP_ANDI) || (op == OP_ORI));
   endfunction

endpackage

// File: rtl/multicycle_next_state.sv
// Combinational next-state logic for the multi-cycle control sequencer.
module multicycle_next_state
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 6
) (
   input  logic [3:0]          state,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                timeout,
   output logic [3:0]          next_state
);

   state_t cur;
   state_t nxt;

   assign cur        = state_t'(state);
   assign next_state = nxt;

   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH: begin
            if (mem_ready)    nxt = S_DECODE;
            else              nxt = S_FETCH;
         end
         S_DECODE: begin
            if (opcode == OP_RTYPE)                        nxt = S_R_EXEC;
            else if (opcode == OP_LW || opcode == OP_SW)   nxt = S_MEM_ADDR;
            else if (opcode == OP_BEQ)                     nxt = S_BRANCH;
            else if (opcode == OP_J)                       nxt = S_JUMP;
            else if (is_imm_op(opcode))                    nxt = S_IMM_EXEC;
            else                                           nxt = S_FETCH;
         end
         S_MEM_ADDR:  nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: begin
            if (mem_ready)    nxt = S_MEM_WB;
            else if (timeout) nxt = S_FETCH;
            else              nxt = S_MEM_READ;
         end
         S_MEM_WRITE: begin
            if (mem_ready || timeout) nxt = S_FETCH;
            else                      nxt = S_MEM_WRITE;
         end
         S_R_EXEC:    nxt = S_R_WB;
         S_IMM_EXEC:  nxt = S_IMM_WB;
         default:     nxt = S_FETCH;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Main control sequencer for the multi-cycle MIPS datapath: state register,
// memory-wait counter and Moore output decode.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int OPCODE_W     = 6,
   parameter int MEM_WAIT_MAX = 0,
   parameter int WAIT_CNT_W   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [2:0]          alu_op,
   output logic [1:0]          pc_source,
   output logic                ext_op,
   output logic                illegal_op,
   output logic                mem_timeout,
   output logic                instr_done
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

   state_t                state;
   logic [3:0]            next_state;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  in_mem_state;
   logic                  timeout;
   logic                  unused_zero;

   // zero is consumed by the PC write-enable logic in the datapath, not here.
   assign unused_zero  = zero;
   assign in_mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
   assign timeout      = (MEM_WAIT_MAX != 0) && in_mem_state && !mem_ready
                         && (wait_cnt == WAIT_LIMIT);

   multicycle_next_state #(
      .OPCODE_W (OPCODE_W)
   ) u_next_state (
      .state      (state),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .timeout    (timeout),
      .next_state (next_state)
   );

   // A timeout re-enters FETCH from itself, so it must clear the counter too.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_t'(next_state);
         if ((next_state != state) || timeout)
            wait_cnt <= '0;
         else if (in_mem_state && !mem_ready && (wait_cnt != '1))
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = ALU_B_REG;
      alu_op        = ALU_OP_ADD;
      pc_source     = PC_SRC_ALU;
      ext_op        = 1'b1;
      illegal_op    = 1'b0;
      mem_timeout   = timeout;
      instr_done    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = ALU_B_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b  = ALU_B_IMM_SH2;
            illegal_op = !((opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW)
                           || (opcode == OP_BEQ) || (opcode == OP_J) || is_imm_op(opcode));
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_IMM;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write  = 1'b1;
            i_or_d     = 1'b1;
            instr_done = mem_ready;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_FUNCT;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_OP_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PC_SRC_ALUOUT;
            instr_done    = 1'b1;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = PC_SRC_JUMP;
            instr_done = 1'b1;
         end
         S_IMM_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = ALU_B_IMM;
            alu_op    = imm_alu_op(opcode);
            ext_op    = imm_ext_op(opcode);
         end
         S_IMM_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            alu_op     = imm_alu_op(opcode);
            ext_op     = imm_ext_op(opcode);
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control with a 4-cycle memory wait limit.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       ext_op;
    logic       illegal_op;
    logic       mem_timeout;
    logic       instr_done;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       zro;
    logic       rdy;
    outs_t      exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  outs_t      got;

  int checks = 0;
  int passed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W     (6),
    .MEM_WAIT_MAX (4),
    .WAIT_CNT_W   (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (got.pc_write),
    .pc_write_cond (got.pc_write_cond),
    .i_or_d        (got.i_or_d),
    .mem_read      (got.mem_read),
    .mem_write     (got.mem_write),
    .ir_write      (got.ir_write),
    .mem_to_reg    (got.mem_to_reg),
    .reg_dst       (got.reg_dst),
    .reg_write     (got.reg_write),
    .alu_src_a     (got.alu_src_a),
    .alu_src_b     (got.alu_src_b),
    .alu_op        (got.alu_op),
    .pc_source     (got.pc_source),
    .ext_op        (got.ext_op),
    .illegal_op    (got.illegal_op),
    .mem_timeout   (got.mem_timeout),
    .instr_done    (got.instr_done)
  );

  // Hand-written expected output sets, one per state.
  function automatic outs_t base();
    outs_t o = '0;
    o.ext_op = 1'b1;
    return o;
  endfunction
  function automatic outs_t e_fetch(logic rdy, logic to);
    outs_t o = base();
    o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; o.mem_timeout = to;
    return o;
  endfunction
  function automatic outs_t e_decode(logic ill);
    outs_t o = base();
    o.alu_src_b = 2'b11; o.illegal_op = ill;
    return o;
  endfunction
  function automatic outs_t e_memaddr();
    outs_t o = base();
    o.alu_src_a = 1; o.alu_src_b = 2'b10;
    return o;
  endfunction
  function automatic outs_t e_memread();
    outs_t o = base();
    o.mem_read = 1; o.i_or_d = 1;
    return o;
  endfunction
  function automatic outs_t e_memwb();
    outs_t o = base();
    o.reg_write = 1; o.mem_to_reg = 1; o.instr_done = 1;
    return o;
  endfunction
  function automatic outs_t e_memwrite(logic rdy, logic to);
    outs_t o = base();
    o.mem_write = 1; o.i_or_d = 1; o.instr_done = rdy; o.mem_timeout = to;
    return o;
  endfunction
  function automatic outs_t e_rexec();
    outs_t o = base();
    o.alu_src_a = 1; o.alu_op = 3'b010;
    return o;
  endfunction
  function automatic outs_t e_rwb();
    outs_t o = base();
    o.reg_write = 1; o.reg_dst = 1; o.instr_done = 1;
    return o;
  endfunction
  function automatic outs_t e_branch();
    outs_t o = base();
    o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_write_cond = 1; o.pc_source = 2'b01; o.instr_done = 1;
    return o;
  endfunction
  function automatic outs_t e_jump();
    outs_t o = base();
    o.pc_write = 1; o.pc_source = 2'b10; o.instr_done = 1;
    return o;
  endfunction
  function automatic outs_t e_iexec(logic [2:0] aop, logic ext);
    outs_t o = base();
    o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = aop; o.ext_op = ext;
    return o;
  endfunction
  function automatic outs_t e_iwb(logic [2:0] aop, logic ext);
    outs_t o = base();
    o.reg_write = 1; o.instr_done = 1; o.alu_op = aop; o.ext_op = ext;
    return o;
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic zro, input logic rdy,
                     input outs_t exp, input string name);
    vec_t v;
    v.rst = rst; v.op = op; v.zro = zro; v.rdy = rdy; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string name, input outs_t exp);
    checks++;
    if (got === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  initial begin
    reset = 1'b1; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;

    add(1, 6'b100011, 0, 0, e_fetch(0, 0),        "reset_state");
    add(0, 6'b100011, 0, 1, e_fetch(1, 0),        "lw_fetch");
    add(0, 6'b100011, 0, 1, e_decode(0),          "lw_decode");
    add(0, 6'b100011, 0, 1, e_memaddr(),          "lw_memaddr");
    add(0, 6'b100011, 0, 1, e_memread(),          "lw_memread");
    add(0, 6'b100011, 0, 1, e_memwb(),            "lw_memwb");
    add(0, 6'b001100, 0, 1, e_fetch(1, 0),        "andi_fetch");
    add(0, 6'b001100, 0, 1, e_decode(0),          "andi_decode");
    add(0, 6'b001100, 0, 1, e_iexec(3'b011, 0),   "andi_exec");
    add(0, 6'b001100, 0, 1, e_iwb(3'b011, 0),     "andi_wb");
    add(0, 6'b001000, 0, 1, e_fetch(1, 0),        "addi_fetch");
    add(0, 6'b001000, 0, 1, e_decode(0),          "addi_decode");
    add(0, 6'b001000, 0, 1, e_iexec(3'b000, 1),   "addi_exec");
    add(0, 6'b001000, 0, 1, e_iwb(3'b000, 1),     "addi_wb");
    add(0, 6'b000100, 1, 1, e_fetch(1, 0),        "beq_fetch");
    add(0, 6'b000100, 1, 1, e_decode(0),          "beq_decode");
    add(0, 6'b000100, 1, 1, e_branch(),           "beq_branch");
    add(0, 6'b000000, 0, 1, e_fetch(1, 0),        "r_fetch");
    add(0, 6'b000000, 0, 1, e_decode(0),          "r_decode");
    add(0, 6'b000000, 0, 1, e_rexec(),            "r_exec");
    add(0, 6'b000000, 0, 1, e_rwb(),              "r_wb");
    add(0, 6'b000010, 0, 1, e_fetch(1, 0),        "j_fetch");
    add(0, 6'b000010, 0, 1, e_decode(0),          "j_decode");
    add(0, 6'b000010, 0, 1, e_jump(),             "j_jump");
    add(0, 6'b111111, 0, 1, e_fetch(1, 0),        "ill_fetch");
    add(0, 6'b111111, 0, 1, e_decode(1),          "ill_decode");
    // sw that times out after four cycles without mem_ready
    add(0, 6'b101011, 0, 1, e_fetch(1, 0),        "ill_back_to_fetch");
    add(0, 6'b101011, 0, 1, e_decode(0),          "swto_decode");
    add(0, 6'b101011, 0, 1, e_memaddr(),          "swto_memaddr");
    add(0, 6'b101011, 0, 0, e_memwrite(0, 0),     "swto_wait1");
    add(0, 6'b101011, 0, 0, e_memwrite(0, 0),     "swto_wait2");
    add(0, 6'b101011, 0, 0, e_memwrite(0, 0),     "swto_wait3");
    add(0, 6'b101011, 0, 0, e_memwrite(0, 1),     "swto_timeout");
    // sw whose mem_ready lands on the limit cycle: ready wins
    add(0, 6'b101011, 0, 1, e_fetch(1, 0),        "swok_fetch");
    add(0, 6'b101011, 0, 1, e_decode(0),          "swok_decode");
    add(0, 6'b101011, 0, 1, e_memaddr(),          "swok_memaddr");
    add(0, 6'b101011, 0, 0, e_memwrite(0, 0),     "swok_wait1");
    add(0, 6'b101011, 0, 0, e_memwrite(0, 0),     "swok_wait2");
    add(0, 6'b101011, 0, 0, e_memwrite(0, 0),     "swok_wait3");
    add(0, 6'b101011, 0, 1, e_memwrite(1, 0),     "swok_done");
    // fetch timeout, then the counter must restart from zero
    add(0, 6'b100011, 0, 0, e_fetch(0, 0),        "fto_wait1");
    add(0, 6'b100011, 0, 0, e_fetch(0, 0),        "fto_wait2");
    add(0, 6'b100011, 0, 0, e_fetch(0, 0),        "fto_wait3");
    add(0, 6'b100011, 0, 0, e_fetch(0, 1),        "fto_timeout");
    add(0, 6'b100011, 0, 0, e_fetch(0, 0),        "fto_restart");
    // lw interrupted by reset while waiting in MEM_READ
    add(0, 6'b100011, 0, 1, e_fetch(1, 0),        "rst_lw_fetch");
    add(0, 6'b100011, 0, 1, e_decode(0),          "rst_lw_decode");
    add(0, 6'b100011, 0, 1, e_memaddr(),          "rst_lw_memaddr");
    add(0, 6'b100011, 0, 0, e_memread(),          "rst_lw_memread");
    add(1, 6'b100011, 0, 0, e_fetch(0, 0),        "rst_mid_memread");
    add(0, 6'b100011, 0, 1, e_fetch(1, 0),        "rst_release_fetch");
    add(0, 6'b100011, 0, 1, e_decode(0),          "rst_release_decode");

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ((got.mem_read === 1'b1) && (got.alu_src_b === 2'b01) && (got.alu_op === 3'b000)
        && (got.ext_op === 1'b1) && (got.pc_write === 1'b0) && (got.ir_write === 1'b0)
        && (got.reg_write === 1'b0) && (got.mem_write === 1'b0))
      passed++;
    else
      $display("FAIL reset_hold: got %h", got);

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      opcode    = vecs[i].op;
      zero      = vecs[i].zro;
      mem_ready = vecs[i].rdy;
      #1;
      check_outs(vecs[i].name, vecs[i].exp);
      if (vecs[i].exp.mem_timeout) begin
        checks++;
        if ((got.mem_timeout === 1'b1) && (got.instr_done === 1'b0) && (got.reg_write === 1'b0))
          passed++;
        else
          $display("FAIL %s: expired wait not flagged (mem_timeout=%b instr_done=%b)",
                   vecs[i].name, got.mem_timeout, got.instr_done);
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control sequencer for the multi-cycle MIPS datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write strobe, plus the immediate-extension mode (sign vs zero) for the 16-bit immediate extender.
- Stalls on a memory ready handshake, with an optional wait timeout.

Parameters:
- OPCODE_W, 6: opcode field width (instr[31:26]).
- MEM_WAIT_MAX, 0: maximum cycles to wait for mem_ready in a memory state. 0 means unlimited.
- WAIT_CNT_W, 8: width of the memory-wait counter.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces FETCH.
- opcode  input  6  instr[31:26] from the instruction register.
- zero  input  1  ALU zero flag (beq).
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero=1.
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  instruction register load.
- mem_to_reg  output  1  register writeback select: 0=ALUOut, 1=MDR.
- reg_dst  output  1  destination select: 0=rt, 1=rd.
- reg_write  output  1  register file write.
- alu_src_a  output  1  ALU A select: 0=PC, 1=A.
- alu_src_b  output  2  ALU B select: 00=B, 01=4, 10=ext imm, 11=ext imm<<2.
- alu_op  output  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt.
- pc_source  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- ext_op  output  1  extender mode: 1=sign-extend, 0=zero-extend.
- illegal_op  output  1  one-cycle pulse in DECODE on an unknown opcode.
- mem_timeout  output  1  one-cycle pulse when the memory wait limit expires.
- instr_done  output  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- Outputs are a Moore decode of state, with strobes additionally gated by mem_ready where noted. There are no combinational paths from opcode except in the DECODE, IMM_EXEC and IMM_WB states.
- States (4-bit encoding):
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11
- Reset (asynchronous): state=FETCH and wait_cnt=0. Resulting outputs:
  - mem_read=1, alu_src_b=01, alu_op=000, ext_op=1.
  - All other strobes 0; pc_write and ir_write stay 0 until mem_ready=1.
  - Reset asserted mid-instruction abandons it, with no pending writes.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - ir_write=pc_write=mem_ready.
  - mem_ready=1 → DECODE; otherwise stay in FETCH.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=000, ext_op=1.
  - Next state by opcode:
    - 000000 → R_EXEC
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - 001000 (addi), 001010 (slti), 001100 (andi), 001101 (ori) → IMM_EXEC
    - any other opcode → FETCH, with illegal_op=1 for that cycle.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=000. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. mem_ready=1 → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. mem_ready=1 → FETCH, with instr_done=1 in that cycle.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, instr_done=1 → FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 → FETCH.
- IMM_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - alu_op by opcode: addi=000, slti=101, andi=011, ori=100.
  - ext_op=0 for andi/ori, 1 otherwise.
  - → IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1, ext_op held as in IMM_EXEC → FETCH.
- ext_op=1 in every state not listed above.
- Memory wait counter:
  - wait_cnt clears on entry to FETCH, MEM_READ and MEM_WRITE.
  - It increments each cycle mem_ready=0 in those states.
  - If MEM_WAIT_MAX≠0 and wait_cnt reaches MEM_WAIT_MAX-1 with mem_ready=0: mem_timeout=1, no strobe is issued, next state=FETCH.
  - The counter saturates and does not wrap.
  - If mem_ready=1 arrives in the same cycle as the limit, mem_ready wins: normal transition, no timeout.
- Latency in cycles with zero wait: lw 5, sw 4, R-type 4, immediate 4, beq 3, j 3.

Decomposition:
- Shared package (mips_ctrl_pkg):
  - state encoding constants;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI);
  - ALU_OP_* codes;
  - ALU B-source and PC-source select codes.
- Sub-module: multicycle_next_state, purely combinational (state, opcode, mem_ready, timeout → next state). The state register, wait counter and output decode stay in the top module.

Test Plan:
- Reset mid-MEM_READ (state=3), then release with mem_ready=1 → state=FETCH; mem_read=1, alu_src_b=01, ir_write=1, pc_write=1 in the first cycle.
- lw (opcode 100011), mem_ready always 1 → states 0,1,2,3,4; reg_write=1 with mem_to_reg=1 in cycle 5; instr_done pulses once.
- andi (001100) → ext_op=0 and alu_op=011 in IMM_EXEC and IMM_WB; addi (001000) → ext_op=1, alu_op=000.
- beq with zero=1 → BRANCH asserts pc_write_cond=1, pc_source=01, alu_op=001; next state FETCH after 3 cycles total.
- MEM_WAIT_MAX=4, sw with mem_ready held 0 → mem_write=1 for 4 cycles, mem_timeout pulses on the 4th, then FETCH; a variant with mem_ready=1 on the 4th cycle → no timeout, instr_done=1.
- Opcode 111111 → illegal_op=1 for one cycle in DECODE, next state FETCH, no reg_write, mem_write or pc_write asserted.
